hub75_column_scanner: RTL and testbench

- Drives the HUB75 panel from the column-generator interface. It issues the column index pair, captures the two returned columns and shifts them out over 3 bit-planes using binary code modulation (BCM).
- It also handles latch, OE and row address sequencing.
- Sits between any column source (e.g. the sphere frame generator) and the panel pins. Column sources are combinational, and their results are consumed one cycle after the indices are presented.

---
 rtl/hub75_pkg.sv | 31 +++
 rtl/bcm_oe_timer.sv | 38 +++
 rtl/hub75_column_scanner.sv | 207 ++++++++++++++++++++
 tb/tb_hub75_column_scanner.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared constants for the HUB75 column scanner: FSM state codes, plane count
// and channel bit offsets within an RGB_RES-bit pixel.
package hub75_pkg;

  localparam int unsigned PIX_BITS   = 9;
  localparam int unsigned NUM_PLANES = PIX_BITS / 3;
  localparam int unsigned R_OFS      = 6;
  localparam int unsigned G_OFS      = 3;
  localparam int unsigned B_OFS      = 0;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH0  = 3'd1;
  localparam logic [2:0] ST_FETCH1  = 3'd2;
  localparam logic [2:0] ST_SHIFT   = 3'd3;
  localparam logic [2:0] ST_BLANK   = 3'd4;
  localparam logic [2:0] ST_LATCH   = 3'd5;
  localparam logic [2:0] ST_DISPLAY = 3'd6;

  // {R,G,B} bit of one BCM plane taken from a packed pixel
  function automatic logic [2:0] plane_bits(input logic [PIX_BITS-1:0] px,
                                            input logic [1:0]          plane);
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
    r = px[R_OFS +: 3];
    g = px[G_OFS +: 3];
    b = px[B_OFS +: 3];
    return {r[plane], g[plane], b[plane]};
  endfunction

endpackage

// File: rtl/bcm_oe_timer.sv
// OE-low interval timer for binary code modulation: plane p keeps OE low for
// BASE_OE<<p cycles; done_c marks the final OE-low cycle.
module bcm_oe_timer #(
  parameter int unsigned BASE_OE    = 8,
  parameter int unsigned NUM_PLANES = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [$clog2(NUM_PLANES)-1:0] plane,
  output logic                          oe_n,
  output logic                          done_c
);

  localparam int unsigned CW = $clog2((BASE_OE << (NUM_PLANES - 1)) + 1);

  logic [CW-1:0] cnt_q;

  assign done_c = ~oe_n & (cnt_q == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      oe_n  <= 1'b1;
    end else if (start) begin
      cnt_q <= CW'(BASE_OE << plane);
      oe_n  <= 1'b0;
    end else if (!oe_n) begin
      if (cnt_q == CW'(1)) begin
        cnt_q <= '0;
        oe_n  <= 1'b1;
      end else begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/hub75_column_scanner.sv
// HUB75 panel driver: fetches a column pair per scan address, shifts it out
// over 3 BCM planes and sequences blank, latch, OE and row address.
module hub75_column_scanner
  import hub75_pkg::*;
#(
  parameter int unsigned SCAN_RATE = 32,
  parameter int unsigned NUM_COLS  = 64,
  parameter int unsigned NUM_ROWS  = 64,
  parameter int unsigned RGB_RES   = 9,
  parameter int unsigned BASE_OE   = 8
) (
  input  logic                                    clk_in,
  input  logic                                    rst_n_in,
  input  logic                                    enable_in,
  input  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]   columns_in,
  output logic [$clog2(SCAN_RATE)-1:0]            column_index1_out,
  output logic [$clog2(NUM_COLS)-1:0]             column_index2_out,
  output logic [$clog2(SCAN_RATE)-1:0]            addr_out,
  output logic [2:0]                              rgb1_out,
  output logic [2:0]                              rgb2_out,
  output logic                                    panel_clk_out,
  output logic                                    latch_out,
  output logic                                    oe_n_out,
  output logic                                    frame_done_out
);

  localparam int unsigned AW  = $clog2(SCAN_RATE);
  localparam int unsigned IW  = $clog2(NUM_COLS);
  localparam int unsigned IX  = $clog2(NUM_ROWS);
  localparam int unsigned PW  = IX + 1;
  localparam int unsigned PLW = $clog2(NUM_PLANES);

  logic [2:0]     state_q,  state_d;
  logic [AW-1:0]  a_q,      a_d;
  logic [IW-1:0]  idx2_q,   idx2_d;
  logic [AW-1:0]  addr_q,   addr_d;
  logic [PLW-1:0] plane_q,  plane_d;
  logic [PW-1:0]  pix_q,    pix_d;
  logic           phase_q,  phase_d;
  logic [2:0]     rgb1_q,   rgb1_d;
  logic [2:0]     rgb2_q,   rgb2_d;
  logic           pclk_q,   pclk_d;
  logic           latch_q,  latch_d;
  logic           frame_q,  frame_d;
  logic           resume_q, resume_d;

  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] col_buf_q;

  logic [AW-1:0]  a_inc_c;
  logic [IX-1:0]  pix_nxt_c;
  logic [PLW-1:0] plane_nxt_c;
  logic           oe_start_c;
  logic           oe_done_c;

  assign a_inc_c     = (a_q == AW'(SCAN_RATE - 1)) ? '0 : a_q + AW'(1);
  assign pix_nxt_c   = IX'(pix_q + PW'(1));
  assign plane_nxt_c = plane_q + PLW'(1);

  assign column_index1_out = a_q;
  assign column_index2_out = idx2_q;
  assign addr_out          = addr_q;
  assign rgb1_out          = rgb1_q;
  assign rgb2_out          = rgb2_q;
  assign panel_clk_out     = pclk_q;
  assign latch_out         = latch_q;
  assign frame_done_out    = frame_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      a_q      <= '0;
      idx2_q   <= IW'(SCAN_RATE);
      addr_q   <= '0;
      plane_q  <= '0;
      pix_q    <= '0;
      phase_q  <= 1'b0;
      rgb1_q   <= '0;
      rgb2_q   <= '0;
      pclk_q   <= 1'b0;
      latch_q  <= 1'b0;
      frame_q  <= 1'b0;
      resume_q <= 1'b0;
    end else begin
      a_q      <= a_d;
      idx2_q   <= idx2_d;
      addr_q   <= addr_d;
      plane_q  <= plane_d;
      pix_q    <= pix_d;
      phase_q  <= phase_d;
      rgb1_q   <= rgb1_d;
      rgb2_q   <= rgb2_d;
      pclk_q   <= pclk_d;
      latch_q  <= latch_d;
      frame_q  <= frame_d;
      resume_q <= resume_d;
    end
  end

  // One capture per address; every plane of that address reuses it
  always_ff @(posedge clk_in) begin
    if (state_q == ST_FETCH1) col_buf_q <= columns_in;
  end

  // Next-state and next-output logic; outputs are loaded with the value of
  // the state being entered so they line up with that state's cycles.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    idx2_d     = idx2_q;
    addr_d     = addr_q;
    plane_d    = plane_q;
    pix_d      = pix_q;
    phase_d    = phase_q;
    rgb1_d     = rgb1_q;
    rgb2_d     = rgb2_q;
    pclk_d     = 1'b0;
    latch_d    = 1'b0;
    frame_d    = 1'b0;
    resume_d   = resume_q;
    oe_start_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable_in) begin
          state_d  = ST_FETCH0;
          resume_d = 1'b0;
          if (resume_q) begin
            a_d    = a_inc_c;
            idx2_d = IW'(a_inc_c) + IW'(SCAN_RATE);
          end
        end
      end
      ST_FETCH0: state_d = ST_FETCH1;
      ST_FETCH1: begin
        // Pixel 0 of plane 0 bypasses the buffer, which loads on this same edge
        state_d = ST_SHIFT;
        plane_d = '0;
        pix_d   = '0;
        phase_d = 1'b0;
        rgb1_d  = plane_bits(columns_in[0][0], 2'd0);
        rgb2_d  = plane_bits(columns_in[1][0], 2'd0);
      end
      ST_SHIFT: begin
        if (!phase_q) begin
          phase_d = 1'b1;
          pclk_d  = 1'b1;
        end else if (pix_q == PW'(NUM_ROWS - 1)) begin
          state_d = ST_BLANK;
        end else begin
          pix_d   = pix_q + PW'(1);
          phase_d = 1'b0;
          rgb1_d  = plane_bits(col_buf_q[0][pix_nxt_c], 2'(plane_q));
          rgb2_d  = plane_bits(col_buf_q[1][pix_nxt_c], 2'(plane_q));
        end
      end
      ST_BLANK: begin
        state_d = ST_LATCH;
        latch_d = 1'b1;
        addr_d  = a_q;
      end
      ST_LATCH: begin
        state_d    = ST_DISPLAY;
        oe_start_c = 1'b1;
      end
      ST_DISPLAY: begin
        if (oe_done_c) begin
          if (plane_q < PLW'(NUM_PLANES - 1)) begin
            state_d = ST_SHIFT;
            plane_d = plane_nxt_c;
            pix_d   = '0;
            phase_d = 1'b0;
            rgb1_d  = plane_bits(col_buf_q[0][0], 2'(plane_nxt_c));
            rgb2_d  = plane_bits(col_buf_q[1][0], 2'(plane_nxt_c));
          end else begin
            frame_d = (a_q == AW'(SCAN_RATE - 1));
            if (enable_in) begin
              state_d = ST_FETCH0;
              a_d     = a_inc_c;
              idx2_d  = IW'(a_inc_c) + IW'(SCAN_RATE);
            end else begin
              state_d  = ST_IDLE;
              resume_d = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  bcm_oe_timer #(
    .BASE_OE    (BASE_OE),
    .NUM_PLANES (NUM_PLANES)
  ) u_oe_timer (
    .clk    (clk_in),
    .rst_n  (rst_n_in),
    .start  (oe_start_c),
    .plane  (plane_q),
    .oe_n   (oe_n_out),
    .done_c (oe_done_c)
  );

endmodule

// File: tb/tb_hub75_column_scanner.sv
// Self-checking bench for hub75_column_scanner: a hashed column source feeds
// the DUT, and each address is checked plane by plane against the pixel rules.
module tb_hub75_column_scanner;

  localparam int unsigned SCAN_RATE = 32;
  localparam int unsigned NUM_ROWS  = 64;
  localparam int unsigned RGB_RES   = 9;
  localparam int unsigned BASE_OE   = 8;
  localparam int          ADDR_CYC  = 448;

  logic clk_in = 1'b0;
  logic rst_n_in;
  logic enable_in;
  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] columns_in;
  logic [4:0] column_index1_out;
  logic [5:0] column_index2_out;
  logic [4:0] addr_out;
  logic [2:0] rgb1_out;
  logic [2:0] rgb2_out;
  logic       panel_clk_out;
  logic       latch_out;
  logic       oe_n_out;
  logic       frame_done_out;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          fd_count = 0;
  int unsigned seed;
  bit          directed;
  logic        pclk_prev;
  int          prev_start;
  bit          have_prev;

  hub75_column_scanner #(
    .SCAN_RATE (SCAN_RATE),
    .NUM_COLS  (2 * SCAN_RATE),
    .NUM_ROWS  (NUM_ROWS),
    .RGB_RES   (RGB_RES),
    .BASE_OE   (BASE_OE)
  ) dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .enable_in         (enable_in),
    .columns_in        (columns_in),
    .column_index1_out (column_index1_out),
    .column_index2_out (column_index2_out),
    .addr_out          (addr_out),
    .rgb1_out          (rgb1_out),
    .rgb2_out          (rgb2_out),
    .panel_clk_out     (panel_clk_out),
    .latch_out         (latch_out),
    .oe_n_out          (oe_n_out),
    .frame_done_out    (frame_done_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) if (rst_n_in && frame_done_out) fd_count <= fd_count + 1;

  // Pixel content of column `col`, row `row` for a given source seed
  function automatic logic [8:0] pix_val(input int unsigned s, input bit dir,
                                         input int unsigned col, input int unsigned row);
    logic [31:0] h;
    if (dir) return (col == 0 && row == 5) ? 9'b101_010_111 : 9'd0;
    h = s ^ (col * 32'h9E37_79B1) ^ (row * 32'h85EB_CA6B);
    h = h ^ (h >> 13);
    h = h * 32'hC2B2_AE35;
    h = h ^ (h >> 16);
    return h[8:0];
  endfunction

  // {R,G,B} bit p of a pixel laid out R=[8:6], G=[5:3], B=[2:0]
  function automatic logic [2:0] exp_bits(input logic [8:0] pix, input int p);
    int v;
    logic [2:0] o;
    v = int'(pix);
    o[2] = ((v >> (6 + p)) & 1) != 0;
    o[1] = ((v >> (3 + p)) & 1) != 0;
    o[0] = ((v >> p) & 1) != 0;
    return o;
  endfunction

  // Combinational column source answering the indices the DUT presents
  always_comb begin
    for (int r = 0; r < NUM_ROWS; r++) begin
      columns_in[0][r] = pix_val(seed, directed, int'(column_index1_out), r);
      columns_in[1][r] = pix_val(seed, directed, int'(column_index2_out), r);
    end
  end

  task automatic check(input string tag, input logic [383:0] got, input logic [383:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Follows one full address; returns on the cycle after its last DISPLAY
  task automatic run_address(input int a, input bit drop_en);
    int unsigned seed_cap;
    logic [383:0] obs;
    logic [383:0] exp_v;
    int edges;
    int guard;
    int width;
    bit oe_bad;
    int na;
    seed_cap = seed;
    for (int p = 0; p < 3; p++) begin
      if (drop_en && p == 1) enable_in = 1'b0;
      edges = 0; guard = 0; oe_bad = 1'b0; obs = '0; exp_v = '0;
      for (int i = 0; i < NUM_ROWS; i++)
        exp_v[i*6 +: 6] = {exp_bits(pix_val(seed_cap, directed, a, i), p),
                           exp_bits(pix_val(seed_cap, directed, a + SCAN_RATE, i), p)};
      while (latch_out !== 1'b1 && guard < 400) begin
        @(negedge clk_in);
        guard++;
        if (panel_clk_out === 1'b1 && pclk_prev === 1'b0) begin
          if (edges < NUM_ROWS) obs[edges*6 +: 6] = {rgb1_out, rgb2_out};
          if (edges == 0 && p == 0) begin
            check("index1", column_index1_out, a);
            check("index2", column_index2_out, a + SCAN_RATE);
            if (have_prev) check("addr_period", cyc - prev_start, ADDR_CYC);
            prev_start = cyc;
            have_prev  = 1'b1;
            // Source changes after capture must not reach the panel
            seed = $urandom;
          end
          edges++;
        end
        if (oe_n_out !== 1'b1) oe_bad = 1'b1;
        pclk_prev = panel_clk_out;
      end
      check("pclk_edges", edges, NUM_ROWS);
      check("plane_data", obs, exp_v);
      check("oe_high_shift_latch", oe_bad, 1'b0);
      check("latch_addr", addr_out, a);
      guard = 0;
      while (oe_n_out === 1'b1 && guard < 10) begin
        @(negedge clk_in);
        guard++;
      end
      width = 0;
      while (oe_n_out === 1'b0 && width < 200) begin
        width++;
        @(negedge clk_in);
      end
      check("oe_width", width, BASE_OE << p);
      check("frame_done", frame_done_out, (p == 2 && a == SCAN_RATE - 1));
      pclk_prev = panel_clk_out;
    end
    na = drop_en ? a : (a + 1) % SCAN_RATE;
    check("next_index1", column_index1_out, na);
    check("next_index2", column_index2_out, na + SCAN_RATE);
  endtask

  initial begin
    int guard;
    bit bad;
    rst_n_in  = 1'b0;
    enable_in = 1'b0;
    seed      = 32'h1234_5678;
    directed  = 1'b1;
    pclk_prev = 1'b0;
    have_prev = 1'b0;
    prev_start = 0;
    repeat (2) @(negedge clk_in);
    check("rst_oe_n", oe_n_out, 1'b1);
    check("rst_latch", latch_out, 1'b0);
    check("rst_addr", addr_out, 0);
    check("rst_index1", column_index1_out, 0);
    check("rst_index2", column_index2_out, SCAN_RATE);
    check("rst_frame_done", frame_done_out, 1'b0);
    check("rst_pclk", panel_clk_out, 1'b0);

    rst_n_in = 1'b1;
    @(negedge clk_in);
    check("idle_oe_n", oe_n_out, 1'b1);
    enable_in = 1'b1;
    run_address(0, 1'b0);
    directed = 1'b0;
    for (int a = 1; a < SCAN_RATE; a++) run_address(a, 1'b0);
    run_address(0, 1'b0);
    check("frame_count_wrap", fd_count, 1);
    run_address(1, 1'b0);
    run_address(2, 1'b0);
    run_address(3, 1'b1);

    bad = 1'b0;
    repeat (20) begin
      @(negedge clk_in);
      if (oe_n_out !== 1'b1 || panel_clk_out !== 1'b0 || latch_out !== 1'b0) bad = 1'b1;
    end
    check("idle_quiet", bad, 1'b0);
    check("idle_hold_index", column_index1_out, 3);

    have_prev = 1'b0;
    enable_in = 1'b1;
    guard = 0;
    do begin
      @(negedge clk_in);
      guard++;
    end while (panel_clk_out !== 1'b1 && guard < 20);
    check("restart_shift_seen", panel_clk_out, 1'b1);
    check("restart_index1", column_index1_out, 4);
    check("restart_index2", column_index2_out, 4 + SCAN_RATE);

    #2 rst_n_in = 1'b0;
    #1;
    check("async_oe_n", oe_n_out, 1'b1);
    check("async_pclk", panel_clk_out, 1'b0);
    check("async_index1", column_index1_out, 0);
    check("async_index2", column_index2_out, SCAN_RATE);
    check("async_addr", addr_out, 0);
    check("async_rgb", {rgb1_out, rgb2_out}, 6'd0);
    check("async_latch", latch_out, 1'b0);

    repeat (2) @(negedge clk_in);
    rst_n_in  = 1'b1;
    pclk_prev = 1'b0;
    seed      = $urandom;
    run_address(0, 1'b0);
    check("frame_count_end", fd_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
